// File: rtl/sharpen_window_sched.sv
// Raster-order window sequencer for the 5-tap cross sharpen kernel: fetches C,N,W,S,E
// per pixel from a 1-cycle-latency single-port memory, zero-fills off-frame taps, presents over valid/ready.
module sharpen_window_sched #(
  parameter int H_SIZE = 512,
  parameter int V_SIZE = 512,
  parameter int PIX_W  = 24,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [PIX_W-1:0]  win_c,
  output logic [PIX_W-1:0]  win_n,
  output logic [PIX_W-1:0]  win_w,
  output logic [PIX_W-1:0]  win_s,
  output logic [PIX_W-1:0]  win_e,
  output logic [15:0]       win_h,
  output logic [15:0]       win_v,
  output logic              win_last
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;

  localparam logic [15:0]       H_LAST = 16'(H_SIZE - 1);
  localparam logic [15:0]       V_LAST = 16'(V_SIZE - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_SIZE);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  state_t      state;
  logic [15:0] h, v;
  logic [2:0]  tap;
  logic        cap_vld, cap_en;
  logic [2:0]  cap_tap;

  logic [15:0] h_nxt, v_nxt;
  logic [2:0]  tap_nxt;
  logic        at_last;

  // Taps are 0=C, 1=N, 2=W, 3=S, 4=E. Offsets are only applied to in-frame taps,
  // so the subtraction/addition can never wrap.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [2:0] t,
                                                  input logic [15:0] hh,
                                                  input logic [15:0] vv);
    logic [ADDR_W-1:0] base;
    base = ADDR_W'(vv) * H_STEP + ADDR_W'(hh);
    case (t)
      3'd1:    tap_addr = base - H_STEP;
      3'd2:    tap_addr = base - ONE;
      3'd3:    tap_addr = base + H_STEP;
      3'd4:    tap_addr = base + ONE;
      default: tap_addr = base;
    endcase
  endfunction

  function automatic logic tap_in_frame(input logic [2:0] t,
                                        input logic [15:0] hh,
                                        input logic [15:0] vv);
    case (t)
      3'd1:    tap_in_frame = (vv != 16'd0);
      3'd2:    tap_in_frame = (hh != 16'd0);
      3'd3:    tap_in_frame = (vv != V_LAST);
      3'd4:    tap_in_frame = (hh != H_LAST);
      default: tap_in_frame = 1'b1;
    endcase
  endfunction

  always_comb begin
    h_nxt   = h + 16'd1;
    v_nxt   = v;
    if (h == H_LAST) begin
      h_nxt = 16'd0;
      v_nxt = v + 16'd1;
    end
    tap_nxt = tap + 3'd1;
    at_last = (h == H_LAST) && (v == V_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      h         <= '0;
      v         <= '0;
      tap       <= '0;
      cap_vld   <= 1'b0;
      cap_en    <= 1'b0;
      cap_tap   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      win_valid <= 1'b0;
      win_c     <= '0;
      win_n     <= '0;
      win_w     <= '0;
      win_s     <= '0;
      win_e     <= '0;
      win_h     <= '0;
      win_v     <= '0;
      win_last  <= 1'b0;
    end else begin
      done    <= 1'b0;
      // Tag the tap issued this cycle; its data is on mem_rd_data next cycle.
      cap_vld <= (state == FETCH);
      cap_tap <= tap;
      cap_en  <= mem_rd_en;

      if (cap_vld) begin
        case (cap_tap)
          3'd0:    win_c <= cap_en ? mem_rd_data : '0;
          3'd1:    win_n <= cap_en ? mem_rd_data : '0;
          3'd2:    win_w <= cap_en ? mem_rd_data : '0;
          3'd3:    win_s <= cap_en ? mem_rd_data : '0;
          default: win_e <= cap_en ? mem_rd_data : '0;
        endcase
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            busy      <= 1'b1;
            h         <= '0;
            v         <= '0;
            tap       <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= tap_addr(3'd0, 16'd0, 16'd0);
          end
        end
        FETCH: begin
          if (tap == 3'd4) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            tap <= tap_nxt;
            if (tap_in_frame(tap_nxt, h, v)) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= tap_addr(tap_nxt, h, v);
            end else begin
              mem_rd_en <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state     <= PRESENT;
          win_valid <= 1'b1;
          win_h     <= h;
          win_v     <= v;
          win_last  <= at_last;
        end
        PRESENT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            if (at_last) begin
              state <= DONE;
            end else begin
              state     <= FETCH;
              h         <= h_nxt;
              v         <= v_nxt;
              tap       <= '0;
              mem_rd_en <= 1'b1;
              mem_addr  <= tap_addr(3'd0, h_nxt, v_nxt);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b1;
          busy      <= 1'b0;
          frame_cnt <= frame_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
